// File: rtl/bp_me_axi_pump_sched_if.sv
// Bundles the AXI address channels, pump burst/beat ports, datapath beat port and B response.
// Latency: none (wires only).
// Backpressure: carried by the ready/yumi/send signals inside the bundle.
interface bp_me_axi_pump_sched_if
  #(parameter int axi_addr_width_p = 64
  , parameter int axi_data_width_p = 64
  );

  localparam int mask_width_lp = axi_data_width_p / 8;

  // AXI write address channel
  logic                        aw_v_i;
  logic                        aw_ready_and_o;
  logic [axi_addr_width_p-1:0] aw_addr_i;
  logic [1:0]                  aw_burst_i;
  logic [7:0]                  aw_len_i;
  logic [2:0]                  aw_size_i;

  // AXI read address channel
  logic                        ar_v_i;
  logic                        ar_ready_and_o;
  logic [axi_addr_width_p-1:0] ar_addr_i;
  logic [1:0]                  ar_burst_i;
  logic [7:0]                  ar_len_i;
  logic [2:0]                  ar_size_i;

  // Burst handed to the pump
  logic                        pump_v_o;
  logic                        pump_ready_and_i;
  logic [axi_addr_width_p-1:0] pump_addr_o;
  logic [1:0]                  pump_burst_o;
  logic [7:0]                  pump_len_o;
  logic [2:0]                  pump_size_o;

  // Per-beat information coming back from the pump
  logic                        pump_v_i;
  logic                        pump_send_o;
  logic [axi_addr_width_p-1:0] pump_addr_i;
  logic [mask_width_lp-1:0]    pump_mask_i;
  logic                        pump_first_i;
  logic                        pump_last_i;

  // Beats towards the memory-side datapath
  logic                        tx_v_o;
  logic                        tx_yumi_i;
  logic                        tx_w_o;
  logic                        tx_err_o;
  logic [axi_addr_width_p-1:0] tx_addr_o;
  logic [mask_width_lp-1:0]    tx_mask_o;
  logic                        tx_first_o;
  logic                        tx_last_o;

  // Write response
  logic                        b_v_o;
  logic                        b_ready_and_i;
  logic [1:0]                  b_resp_o;

  // Scheduler side
  modport slave
    (input  aw_v_i, aw_addr_i, aw_burst_i, aw_len_i, aw_size_i
    ,output aw_ready_and_o
    ,input  ar_v_i, ar_addr_i, ar_burst_i, ar_len_i, ar_size_i
    ,output ar_ready_and_o
    ,output pump_v_o, pump_addr_o, pump_burst_o, pump_len_o, pump_size_o
    ,input  pump_ready_and_i
    ,input  pump_v_i, pump_addr_i, pump_mask_i, pump_first_i, pump_last_i
    ,output pump_send_o
    ,output tx_v_o, tx_w_o, tx_err_o, tx_addr_o, tx_mask_o, tx_first_o, tx_last_o
    ,input  tx_yumi_i
    ,output b_v_o, b_resp_o
    ,input  b_ready_and_i
    );

  // Front-end / pump / datapath side
  modport master
    (output aw_v_i, aw_addr_i, aw_burst_i, aw_len_i, aw_size_i
    ,input  aw_ready_and_o
    ,output ar_v_i, ar_addr_i, ar_burst_i, ar_len_i, ar_size_i
    ,input  ar_ready_and_o
    ,input  pump_v_o, pump_addr_o, pump_burst_o, pump_len_o, pump_size_o
    ,output pump_ready_and_i
    ,output pump_v_i, pump_addr_i, pump_mask_i, pump_first_i, pump_last_i
    ,input  pump_send_o
    ,input  tx_v_o, tx_w_o, tx_err_o, tx_addr_o, tx_mask_o, tx_first_o, tx_last_o
    ,output tx_yumi_i
    ,input  b_v_o, b_resp_o
    ,output b_ready_and_i
    );

endinterface

// File: rtl/bp_me_axi_pump_sched.sv
// Round-robin AW/AR scheduler feeding one shared transfer pump, streams beats and issues B.
// Latency: grant is combinational in IDLE; beats follow the pump; B the cycle after the last write beat.
// Backpressure: pump_ready gates AW/AR ready; tx_yumi stalls the pump; b_ready holds BRESP.
module bp_me_axi_pump_sched
  #(parameter int axi_addr_width_p = 64
  , parameter int axi_data_width_p = 64
  )
  (input  logic clk_i
  ,input  logic reset_n_i
  ,bp_me_axi_pump_sched_if.slave io
  );

  localparam int lg_bytes_lp = $clog2(axi_data_width_p / 8);

  typedef enum logic [1:0] {e_idle, e_busy, e_bresp} state_e;

  state_e state_r, state_n;

  // last_grant_w_r: 1 when the most recent grant went to AW
  logic last_grant_w_r, err_r, is_w_r;

  logic                        any_v, grant_w, accept, illegal, beat_done;
  logic [axi_addr_width_p-1:0] win_addr, align_mask;
  logic [1:0]                  win_burst;
  logic [7:0]                  win_len;
  logic [2:0]                  win_size;

  // Pick the winner: a lone valid wins, otherwise the channel not granted last time
  always_comb begin
    any_v     = io.aw_v_i | io.ar_v_i;
    grant_w   = io.aw_v_i & (~io.ar_v_i | ~last_grant_w_r);
    win_addr  = grant_w ? io.aw_addr_i  : io.ar_addr_i;
    win_burst = grant_w ? io.aw_burst_i : io.ar_burst_i;
    win_len   = grant_w ? io.aw_len_i   : io.ar_len_i;
    win_size  = grant_w ? io.aw_size_i  : io.ar_size_i;
    accept    = (state_r == e_idle) & any_v & io.pump_ready_and_i;
    beat_done = (state_r == e_busy) & io.pump_v_i & io.tx_yumi_i & io.pump_last_i;
  end

  // Classify the winning burst; illegal ones still run so the beat count is honoured
  always_comb begin
    align_mask = ~({axi_addr_width_p{1'b1}} << win_size);
    illegal    = 1'b0;
    if (win_burst == 2'b11)
      illegal = 1'b1;
    if (win_burst == 2'b10) begin
      if (!(win_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
        illegal = 1'b1;
      if ((win_addr & align_mask) != '0)
        illegal = 1'b1;
    end
    if (int'(win_size) > lg_bytes_lp)
      illegal = 1'b1;
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      state_r <= e_idle;
    else
      state_r <= state_n;
  end

  // Burst attributes captured at acceptance and round-robin history
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_grant_w_r <= 1'b0;
      err_r          <= 1'b0;
      is_w_r         <= 1'b0;
    end else if (accept) begin
      last_grant_w_r <= grant_w;
      err_r          <= illegal;
      is_w_r         <= grant_w;
    end
  end

  // Next-state: one burst in flight, writes detour through BRESP
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_idle:  if (accept)           state_n = e_busy;
      e_busy:  if (beat_done)        state_n = is_w_r ? e_bresp : e_idle;
      e_bresp: if (io.b_ready_and_i) state_n = e_idle;
      default:                       state_n = e_idle;
    endcase
  end

  // Outputs; handshakes are forced low while reset is held so nothing leaks combinationally
  always_comb begin
    io.aw_ready_and_o = 1'b0;
    io.ar_ready_and_o = 1'b0;
    io.pump_v_o       = 1'b0;
    io.pump_send_o    = 1'b0;
    io.tx_v_o         = 1'b0;
    io.b_v_o          = 1'b0;
    io.pump_addr_o    = win_addr;
    io.pump_burst_o   = illegal ? 2'b01 : win_burst;
    io.pump_len_o     = win_len;
    io.pump_size_o    = win_size;
    io.tx_w_o         = is_w_r;
    io.tx_err_o       = err_r;
    io.tx_addr_o      = io.pump_addr_i;
    io.tx_mask_o      = io.pump_mask_i;
    io.tx_first_o     = io.pump_first_i;
    io.tx_last_o      = io.pump_last_i;
    io.b_resp_o       = (reset_n_i && state_r == e_bresp && err_r) ? 2'b10 : 2'b00;
    if (reset_n_i) begin
      unique case (state_r)
        e_idle: begin
          io.pump_v_o       = any_v;
          io.aw_ready_and_o = grant_w & io.pump_ready_and_i;
          io.ar_ready_and_o = ~grant_w & io.ar_v_i & io.pump_ready_and_i;
        end
        e_busy: begin
          io.tx_v_o      = io.pump_v_i;
          io.pump_send_o = io.tx_yumi_i & io.pump_v_i;
        end
        e_bresp: io.b_v_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_me_axi_pump_sched.sv
// Bench: environment pump + AXI request queues around the scheduler, checked against a transaction model.
// Latency: n/a.
// Backpressure: randomised pump stalls, tx_yumi and b_ready.
module tb_bp_me_axi_pump_sched;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  bp_me_axi_pump_sched_if #(.axi_addr_width_p(64), .axi_data_width_p(64)) io ();

  bp_me_axi_pump_sched #(.axi_addr_width_p(64), .axi_data_width_p(64)) dut
    (.clk_i(clk_i), .reset_n_i(reset_n_i), .io(io));

  typedef struct { logic [63:0] addr; logic [1:0] burst; logic [7:0] len; logic [2:0] size; } req_t;
  typedef struct { logic [63:0] addr; logic [7:0] mask; logic w, err, first, last; } beat_t;

  req_t  aw_q[$], ar_q[$];
  beat_t exp_q[$];
  logic [1:0] expb_q[$];
  bit    glog[$];

  int checks = 0, errors = 0;
  int m_phase = 0;           // 0 idle, 1 data beats, 2 awaiting B
  bit m_last_w = 1'b0;       // last grant was a write
  int tx_cnt = 0;
  int yumi_mode = 1, bready_mode = 1, stall_pct = 0;
  bit hold_v = 1'b1;
  bit hold_pend = 1'b0;
  logic [63:0] hold_addr;

  // environment pump state
  bit          p_busy = 1'b0, p_show = 1'b0;
  logic [63:0] p_addr, p_bytes, p_wb, p_lower;
  logic [1:0]  p_burst;
  logic [7:0]  p_len, p_cnt;
  logic [2:0]  p_size;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit is_illegal(input req_t r);
    if (r.burst == 2'b11) return 1'b1;
    if (r.burst == 2'b10 && !(r.len == 1 || r.len == 3 || r.len == 7 || r.len == 15)) return 1'b1;
    if (r.burst == 2'b10 && (r.addr % (64'd1 << r.size)) != 0) return 1'b1;
    if (r.size > 3) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] lane_mask(input logic [63:0] a, input logic [2:0] s);
    int bytes, lane;
    if (s >= 3) return 8'hFF;
    bytes = 1 << s;
    lane  = int'(a[2:0]) & ~(bytes - 1);
    return 8'(((1 << bytes) - 1) << lane);
  endfunction

  // Expected beats straight from the AXI burst rules (closed form per beat index)
  function automatic void push_expected(input req_t r, input bit w);
    bit err;
    logic [1:0]  b;
    logic [63:0] bytes, wb, lower, a;
    err   = is_illegal(r);
    b     = err ? 2'b01 : r.burst;
    bytes = 64'd1 << r.size;
    wb    = bytes * (64'(r.len) + 64'd1);
    lower = r.addr - (r.addr % wb);
    for (int i = 0; i <= int'(r.len); i++) begin
      beat_t e;
      if (b == 2'b00)      a = r.addr;
      else if (b == 2'b01) a = (i == 0) ? r.addr : (r.addr - r.addr % bytes) + 64'(i) * bytes;
      else                 a = lower + ((r.addr - lower + 64'(i) * bytes) % wb);
      e.addr = a; e.mask = lane_mask(a, r.size); e.w = w; e.err = err;
      e.first = (i == 0); e.last = (i == int'(r.len));
      exp_q.push_back(e);
    end
    if (w) expb_q.push_back(err ? 2'b10 : 2'b00);
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int k;
    k = $urandom_range(0, 9);
    r.size  = (k == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
    r.burst = 2'($urandom_range(0, 3));
    if (r.burst == 2'b10 && k != 1) r.len = 8'((1 << $urandom_range(1, 4)) - 1);
    else                            r.len = 8'($urandom_range(0, 9));
    r.addr = {48'h0, 16'($urandom)};
    if (r.burst == 2'b10 && k != 2) r.addr = r.addr & ~((64'd1 << r.size) - 64'd1);
    return r;
  endfunction

  task automatic drive_inputs(input bit aw_hs, input bit ar_hs);
    bit keep;
    keep = io.aw_v_i && !aw_hs;
    io.aw_v_i = (aw_q.size() != 0) && (keep || hold_v || $urandom_range(0, 2) != 0);
    if (aw_q.size() != 0) begin
      io.aw_addr_i = aw_q[0].addr; io.aw_burst_i = aw_q[0].burst;
      io.aw_len_i = aw_q[0].len; io.aw_size_i = aw_q[0].size;
    end
    keep = io.ar_v_i && !ar_hs;
    io.ar_v_i = (ar_q.size() != 0) && (keep || hold_v || $urandom_range(0, 2) != 0);
    if (ar_q.size() != 0) begin
      io.ar_addr_i = ar_q[0].addr; io.ar_burst_i = ar_q[0].burst;
      io.ar_len_i = ar_q[0].len; io.ar_size_i = ar_q[0].size;
    end
    io.pump_ready_and_i = !p_busy && ($urandom_range(0, 99) >= stall_pct);
    io.pump_v_i     = p_busy && p_show;
    io.pump_addr_i  = p_addr;
    io.pump_mask_i  = lane_mask(p_addr, p_size);
    io.pump_first_i = (p_cnt == 8'd0);
    io.pump_last_i  = (p_cnt == p_len);
    io.tx_yumi_i     = (yumi_mode == 1) || (yumi_mode == 0 && $urandom_range(0, 1) == 1);
    io.b_ready_and_i = (bready_mode == 1) || (bready_mode == 0 && $urandom_range(0, 1) == 1);
  endtask

  // One clock: observe at negedge, react just after posedge
  task automatic step();
    bit aw_hs, ar_hs, pump_hs, send, tx_hs, should_acc, win_w, shown;
    int nphase;
    req_t rq;
    beat_t e;
    logic [63:0] c_addr;
    logic [1:0]  c_burst, eb;
    logic [7:0]  c_len;
    logic [2:0]  c_size;
    @(negedge clk_i);
    nphase  = m_phase;
    aw_hs   = io.aw_v_i & io.aw_ready_and_o;
    ar_hs   = io.ar_v_i & io.ar_ready_and_o;
    pump_hs = io.pump_v_o & io.pump_ready_and_i;
    send    = io.pump_send_o;
    c_addr = io.pump_addr_o; c_burst = io.pump_burst_o; c_len = io.pump_len_o; c_size = io.pump_size_o;
    should_acc = (m_phase == 0) && (io.aw_v_i || io.ar_v_i) && io.pump_ready_and_i;
    if (should_acc || aw_hs || ar_hs) chk("accept", aw_hs | ar_hs, should_acc);
    if (m_phase == 0) chk("pump_v", io.pump_v_o, io.aw_v_i | io.ar_v_i);
    else chk("rdy_busy", {io.aw_ready_and_o, io.ar_ready_and_o, io.pump_v_o}, 0);
    if (aw_hs || ar_hs) begin
      win_w = (io.aw_v_i && io.ar_v_i) ? !m_last_w : io.aw_v_i;
      chk("grant_ch", {aw_hs, ar_hs}, {win_w, !win_w});
      chk("grant_pump_hs", pump_hs, 1);
      if (aw_hs) rq = aw_q[0]; else rq = ar_q[0];
      push_expected(rq, aw_hs);
      m_last_w = aw_hs;
      glog.push_back(aw_hs);
      nphase = 1;
    end
    chk("tx_v", io.tx_v_o, (m_phase == 1) && io.pump_v_i);
    chk("send", io.pump_send_o, (m_phase == 1) && io.pump_v_i && io.tx_yumi_i);
    if (hold_pend) begin
      chk("tx_hold_v", io.tx_v_o, 1);
      chk("tx_hold_addr", io.tx_addr_o, hold_addr);
    end
    hold_pend = io.tx_v_o && !io.tx_yumi_i;
    hold_addr = io.tx_addr_o;
    tx_hs = io.tx_v_o & io.tx_yumi_i;
    if (tx_hs) begin
      tx_cnt++;
      if (exp_q.size() == 0) chk("tx_extra", tx_hs, 0);
      else begin
        e = exp_q.pop_front();
        chk("tx_addr", io.tx_addr_o, e.addr);
        chk("tx_mask", io.tx_mask_o, e.mask);
        chk("tx_w_err_first_last", {io.tx_w_o, io.tx_err_o, io.tx_first_o, io.tx_last_o},
            {e.w, e.err, e.first, e.last});
        if (e.last) nphase = e.w ? 2 : 0;
      end
    end
    chk("b_v", io.b_v_o, m_phase == 2);
    if (io.b_v_o && io.b_ready_and_i) begin
      if (expb_q.size() == 0) chk("b_extra", io.b_v_o, 0);
      else begin
        eb = expb_q.pop_front();
        chk("b_resp", io.b_resp_o, eb);
      end
      nphase = 0;
    end
    @(posedge clk_i);
    #1;
    m_phase = nphase;
    if (aw_hs) void'(aw_q.pop_front());
    if (ar_hs) void'(ar_q.pop_front());
    shown = io.pump_v_i && !send;
    if (p_busy && send) begin
      if (p_cnt == p_len) p_busy = 1'b0;
      else begin
        p_cnt++;
        if (p_burst == 2'b01) p_addr = (p_addr & ~(p_bytes - 64'd1)) + p_bytes;
        else if (p_burst == 2'b10) begin
          p_addr = p_addr + p_bytes;
          if (p_addr >= p_lower + p_wb) p_addr = p_lower;
        end
      end
    end
    if (pump_hs) begin
      p_busy = 1'b1; p_addr = c_addr; p_burst = c_burst; p_len = c_len; p_size = c_size;
      p_cnt = 8'd0; p_bytes = 64'd1 << c_size; p_wb = p_bytes * (64'(c_len) + 64'd1);
      p_lower = c_addr - (c_addr % p_wb);
    end
    if (!shown) p_show = ($urandom_range(0, 99) >= stall_pct);
    drive_inputs(aw_hs, ar_hs);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((aw_q.size() + ar_q.size() + exp_q.size() + expb_q.size()) != 0 || m_phase != 0 || p_busy) begin
      if (n == budget) break;
      step();
      n++;
    end
    chk("drain", aw_q.size() + ar_q.size() + exp_q.size() + expb_q.size() + m_phase + int'(p_busy), 0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_tx_v"}, io.tx_v_o, 0);
    chk({tag, "_b_v"}, io.b_v_o, 0);
    chk({tag, "_b_resp"}, io.b_resp_o, 0);
    chk({tag, "_rdy_pump"}, {io.aw_ready_and_o, io.ar_ready_and_o, io.pump_v_o, io.pump_send_o}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n, start;
    io.aw_v_i = 0; io.ar_v_i = 0; io.pump_ready_and_i = 0; io.pump_v_i = 0;
    io.tx_yumi_i = 0; io.b_ready_and_i = 0;
    io.aw_addr_i = 0; io.aw_burst_i = 0; io.aw_len_i = 0; io.aw_size_i = 0;
    io.ar_addr_i = 0; io.ar_burst_i = 0; io.ar_len_i = 0; io.ar_size_i = 0;
    io.pump_addr_i = 0; io.pump_mask_i = 0; io.pump_first_i = 0; io.pump_last_i = 0;
    p_addr = 0; p_len = 0; p_cnt = 0; p_size = 0; p_burst = 0; p_bytes = 1; p_wb = 1; p_lower = 0;
    hold_addr = 0;

    // reset holds every handshake low even with a request and a ready pump
    #2 io.aw_v_i = 1; io.ar_v_i = 1; io.pump_ready_and_i = 1;
    #1 check_quiet("reset");
    io.aw_v_i = 0; io.ar_v_i = 0; io.pump_ready_and_i = 0;
    @(posedge clk_i); @(posedge clk_i); #1 reset_n_i = 1;

    // directed INCR write then single-beat read
    aw_q.push_back('{64'h100, 2'b01, 8'd3, 3'd3});
    drain(100);
    chk("w1_beats", tx_cnt, 4);
    ar_q.push_back('{64'h40, 2'b01, 8'd0, 3'd2});
    drain(100);
    chk("r1_beats", tx_cnt, 5);

    // contention: grants alternate starting with write
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      aw_q.push_back('{64'h1000 + 64'(i) * 64'h40, 2'b01, 8'(i), 3'd3});
      ar_q.push_back('{64'h2000 + 64'(i) * 64'h40, 2'b00, 8'(i + 1), 3'd2});
    end
    drain(400);
    chk("cont_count", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++) chk("cont_order", glog[i], (i % 2) == 0);

    // illegal WRAP len=2: forced INCR addressing, error tag, SLVERR
    ar_q.push_back('{64'h10, 2'b10, 8'd2, 3'd3});
    drain(100);
    aw_q.push_back('{64'h10, 2'b10, 8'd2, 3'd3});
    drain(100);

    // stalls: tx_yumi low mid-burst, then B held off with an AR waiting
    start = tx_cnt;
    bready_mode = 2;
    aw_q.push_back('{64'h3000, 2'b01, 8'd3, 3'd3});
    n = 0;
    while (tx_cnt < start + 1 && n < 100) begin step(); n++; end
    yumi_mode = 2;
    repeat (5) step();
    yumi_mode = 1;
    ar_q.push_back('{64'h500, 2'b00, 8'd1, 3'd1});
    n = 0;
    while (m_phase != 2 && n < 100) begin step(); n++; end
    repeat (3) step();
    chk("b_stall_v", io.b_v_o, 1);
    chk("ar_blocked", ar_q.size(), 1);
    bready_mode = 1;
    drain(100);

    // asynchronous reset during beat 2 of a len=7 write
    start = tx_cnt;
    aw_q.push_back('{64'h4000, 2'b01, 8'd7, 3'd3});
    n = 0;
    while (tx_cnt < start + 2 && n < 100) begin step(); n++; end
    chk("pre_rst_tx_v", io.tx_v_o, 1);
    #1 reset_n_i = 0;
    #1 check_quiet("mid_rst");
    aw_q.delete(); ar_q.delete(); exp_q.delete(); expb_q.delete();
    m_phase = 0; m_last_w = 1'b0; p_busy = 1'b0; p_show = 1'b0; hold_pend = 1'b0;
    io.aw_v_i = 0; io.ar_v_i = 0; io.pump_v_i = 0;
    @(posedge clk_i); #1 reset_n_i = 1;

    // after reset, first contention goes to write, and the AR follows normally
    glog.delete();
    aw_q.push_back('{64'h600, 2'b01, 8'd1, 3'd3});
    ar_q.push_back('{64'h700, 2'b01, 8'd2, 3'd3});
    drain(100);
    chk("post_rst_count", glog.size(), 2);
    if (glog.size() == 2) chk("post_rst_order", {glog[0], glog[1]}, 2'b10);

    // randomized traffic with backpressure everywhere
    hold_v = 1'b0; yumi_mode = 0; bready_mode = 0; stall_pct = 30;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) aw_q.push_back(rand_req());
      else ar_q.push_back(rand_req());
    end
    drain(8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_me_axi_pump_sched.md
Name: bp_me_axi_pump_sched

Overview:
Address-channel scheduler that shares one AXI transfer pump (per-beat address/mask generator) between an AXI subordinate's AW and AR channels. It arbitrates AW against AR round-robin and loads the winning burst into the pump. It then streams the pump's per-beat outputs to the data-path consumer, tagged read/write. For writes it issues the B response after the last beat. It sits between the AXI subordinate front-end and the memory-side beat datapath.

Parameters:
axi_addr_width_p, 64, AXI address width
axi_data_width_p, 64, AXI data width; mask width = axi_data_width_p/8

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset, asynchronous, active-low
aw_v_i  in  1  write address valid
aw_ready_and_o  out  1  write address ready
aw_addr_i/aw_burst_i/aw_len_i/aw_size_i  in  addr/2/8/3  write burst fields
ar_v_i  in  1  read address valid
ar_ready_and_o  out  1  read address ready
ar_addr_i/ar_burst_i/ar_len_i/ar_size_i  in  addr/2/8/3  read burst fields
pump_v_o  out  1  burst valid to pump
pump_ready_and_i  in  1  pump accepting burst
pump_addr_o/pump_burst_o/pump_len_o/pump_size_o  out  addr/2/8/3  burst fields to pump
pump_v_i  in  1  pump beat valid
pump_send_o  out  1  beat consumed (pump advances)
pump_addr_i/pump_mask_i/pump_first_i/pump_last_i  in  addr/mask/1/1  pump beat info
tx_v_o  out  1  beat valid to datapath
tx_yumi_i  in  1  datapath consumes beat
tx_w_o  out  1  1 = write beat, 0 = read beat
tx_err_o  out  1  beat belongs to illegal burst
tx_addr_o/tx_mask_o/tx_first_o/tx_last_o  out  addr/mask/1/1  beat info passthrough
b_v_o  out  1  write response valid
b_ready_and_i  in  1  write response ready
b_resp_o  out  2  00 OKAY, 10 SLVERR

Behaviour:
- One clock (clk_i). Reset is asynchronous and active-low (reset_n_i). While reset is low: state=IDLE, last_grant=READ, err_r=0, is_w_r=0. All valid/ready outputs (aw_ready_and_o, ar_ready_and_o, pump_v_o, pump_send_o, tx_v_o, b_v_o) are 0; b_resp_o=00.
- States: IDLE, BUSY, BRESP.
- IDLE arbitration (combinational, same cycle):
  - Only one valid: that channel wins.
  - Both valid: the channel not equal to last_grant wins.
  - Winner's fields drive pump_*_o with pump_v_o=1.
  - Winner's ready = pump_ready_and_i; loser's ready = 0.
  - On handshake: latch is_w_r, latch err_r = illegal, set last_grant = winner, go BUSY.
  - No valid: pump_v_o=0 and fields don't-care.
- Illegal burst, decided at acceptance:
  - burst==2'b11, or
  - WRAP with len not in {1,3,7,15}, or
  - WRAP with addr not aligned to 1<<size, or
  - size > log2(axi_data_width_p/8).
  - Illegal bursts are still pumped with pump_burst_o forced to INCR so the beat count is honoured; tx_err_o=err_r on every beat.
- BUSY:
  - tx_v_o = pump_v_i; pump_send_o = tx_yumi_i & pump_v_i.
  - tx_addr/mask/first/last pass through combinationally; tx_w_o = is_w_r.
  - aw_ready_and_o = ar_ready_and_o = pump_v_o = 0.
  - tx_yumi_i while tx_v_o=0 is ignored.
  - On tx_yumi_i & pump_last_i: a write goes to BRESP; a read goes to IDLE.
  - len=0 bursts complete on their first beat.
- BRESP:
  - b_v_o=1; b_resp_o = err_r ? 10 : 00.
  - On b_ready_and_i: go IDLE.
  - No new AW/AR accepted until the response handshake completes.
- Latency: accept to first tx_v_o is at least 1 cycle (pump registers the burst). A new burst can be accepted the cycle after the last beat (read) or the B handshake (write). Throughput is 1 beat/cycle.
- Exactly one burst is in flight; no reordering; AW/AR ready never assert outside IDLE.
- Reset mid-burst (BUSY or BRESP): immediate return to IDLE with outputs cleared. The pump must be reset in the same domain, and no partial B response is issued.
- Fairness: under continuous AW and AR valid, grants strictly alternate W,R,W,R… The first contention after reset goes to write.

Test Plan:
- Reset, then AW{addr=0x100, INCR, len=3, size=3} alone → aw_ready_and_o=1 for 1 cycle. 4 tx beats with tx_w_o=1, addrs 0x100/108/110/118, mask 0xFF, first on beat0, last on beat3. Then b_v_o with b_resp_o=00; then IDLE.
- AR{0x40, INCR, len=0, size=2} → one beat, addr 0x40, mask 0x0F, first=last=1. No b_v_o; ar_ready reasserts the following cycle.
- AW and AR held valid simultaneously for 4 bursts → grant order W,R,W,R; no beats interleave between bursts.
- AR{WRAP, len=2} → accepted; 3 beats with tx_err_o=1 and INCR addressing. Same for an AW → b_resp_o=10.
- tx_yumi_i held 0 for 5 cycles mid-burst, and b_ready_and_i held 0 for 3 cycles → beat and response held stable, pump_send_o=0, no new AW/AR accepted.
- reset_n_i pulsed low during beat 2 of a len=7 write → all valids drop asynchronously. After release, state is IDLE and the next AR is granted normally.
